// File: rtl/word_aligner.sv
// Comma-based word aligner: hunts for a 4'b1101 comma, verifies it at a stable
// bit offset, then emits realigned words while tracking loss of lock.
module word_aligner #(
   parameter int unsigned word_size  = 32,
   parameter int unsigned index_size = 4,
   parameter int unsigned lock_count = 3,
   parameter int unsigned loss_count = 4
) (
   input  logic                  trigger,
   input  logic                  reset,
   input  logic [word_size-1:0]  word_in,
   input  logic                  word_valid,
   input  logic [index_size:0]   index_in,
   output logic [word_size-1:0]  aligned_out,
   output logic                  aligned_valid,
   output logic                  locked,
   output logic [index_size:0]   offset_out
);

   localparam int unsigned IW      = index_size + 1;
   localparam int unsigned CNT_MAX = (lock_count > loss_count) ? lock_count : loss_count;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          offset_q, offset_d;
   logic [CNT_W-1:0]       match_q, match_d;
   logic [CNT_W-1:0]       miss_q, miss_d;
   logic [word_size-1:0]   prev_q, prev_d;
   logic [word_size-1:0]   aligned_q, aligned_d;
   logic                   aligned_valid_q, aligned_valid_d;
   logic                   locked_q, locked_d;

   logic                   comma_c;
   logic [IW-1:0]          comma_off_c;
   logic                   at_offset_c;
   logic [2*word_size-1:0] concat_c;
   logic [word_size-1:0]   aligned_c;
   logic [CNT_W-1:0]       match_inc_c;
   logic [CNT_W-1:0]       miss_inc_c;

   // A comma index is usable only if the full 4-bit pattern fits in the word.
   assign comma_c     = (index_in != '0) && (32'(index_in) <= 32'(word_size - 3));
   assign comma_off_c = IW'(index_in - 1'b1);
   assign at_offset_c = comma_c && (comma_off_c == offset_q);
   assign concat_c    = {word_in, prev_q};
   assign aligned_c   = word_size'(concat_c >> offset_q);
   assign match_inc_c = CNT_W'(match_q + 1'b1);
   assign miss_inc_c  = CNT_W'(miss_q + 1'b1);

   always_comb begin
      state_d         = state_q;
      offset_d        = offset_q;
      match_d         = match_q;
      miss_d          = miss_q;
      prev_d          = prev_q;
      aligned_d       = aligned_q;
      aligned_valid_d = 1'b0;

      if (word_valid) begin
         prev_d = word_in;
         if (state_q == LOCKED) begin
            aligned_d       = aligned_c;
            aligned_valid_d = 1'b1;
         end
         case (state_q)
            HUNT: begin
               if (comma_c) begin
                  offset_d = comma_off_c;
                  match_d  = CNT_W'(1);
                  state_d  = VERIFY;
               end
            end
            VERIFY: begin
               if (at_offset_c) begin
                  match_d = match_inc_c;
                  if (match_inc_c == CNT_W'(lock_count)) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else if (comma_c) begin
                  offset_d = comma_off_c;
                  match_d  = CNT_W'(1);
               end
            end
            LOCKED: begin
               if (at_offset_c) begin
                  miss_d = '0;
               end else if (comma_c) begin
                  miss_d = miss_inc_c;
                  // Lock is dropped without adopting the offending comma's offset.
                  if (miss_inc_c == CNT_W'(loss_count)) begin
                     state_d = HUNT;
                     match_d = '0;
                     miss_d  = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge trigger) begin
      if (reset) begin
         state_q         <= HUNT;
         offset_q        <= '0;
         match_q         <= '0;
         miss_q          <= '0;
         prev_q          <= '0;
         aligned_q       <= '0;
         aligned_valid_q <= 1'b0;
         locked_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         offset_q        <= offset_d;
         match_q         <= match_d;
         miss_q          <= miss_d;
         prev_q          <= prev_d;
         aligned_q       <= aligned_d;
         aligned_valid_q <= aligned_valid_d;
         locked_q        <= locked_d;
      end
   end

   assign aligned_out   = aligned_q;
   assign aligned_valid = aligned_valid_q;
   assign locked        = locked_q;
   assign offset_out    = offset_q;

endmodule

// File: doc/word_aligner.md
WORD_ALIGNER -- requirements
Module: word_aligner

Interface
REQ-001 SHALL have parameter word_size, default 32, width of data words.
REQ-002 SHALL have parameter index_size, default 4, MSB position of index/offset fields (fields are [index_size:0]).
REQ-003 SHALL have parameter lock_count, default 3, matching commas needed to lock.
REQ-004 SHALL have parameter loss_count, default 4, mismatching commas needed to drop lock.
REQ-005 SHALL have port trigger  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port word_in  input  word_size  unaligned data word.
REQ-008 SHALL have port word_valid  input  1  qualifies word_in and index_in this cycle.
REQ-009 SHALL have port index_in  input  index_size+1  comma index for the same word: k in 1..29 = comma 4'b1101 at bits [k+2:k-1]; 0 or 30..31 = no comma.
REQ-010 SHALL have port aligned_out  output  word_size  realigned word, registered.
REQ-011 SHALL have port aligned_valid  output  1  aligned_out valid for this cycle.
REQ-012 SHALL have port locked  output  1  high while state is LOCKED.
REQ-013 SHALL have port offset_out  output  index_size+1  current candidate/locked bit offset (k-1).

Function
REQ-014 SHALL implement states HUNT, VERIFY, LOCKED; all transitions occur only on edges where word_valid=1.
REQ-015 SHALL hold state, counters, prev_word and offset when word_valid=0; aligned_valid=0 the following cycle.
REQ-016 SHALL store word_in into prev_word on every valid word, in every state.
REQ-017 HUNT: valid comma (k in 1..29) -> offset=k-1, match_cnt=1, go VERIFY; no comma -> stay HUNT.
REQ-018 VERIFY: comma at offset -> match_cnt+1; when incremented value equals lock_count go LOCKED, miss_cnt=0.
REQ-019 VERIFY: comma at different offset -> offset=new k-1, match_cnt=1, stay VERIFY; no comma -> no change.
REQ-020 LOCKED: comma at offset -> miss_cnt=0; comma at other offset -> miss_cnt+1; no comma -> no change.
REQ-021 LOCKED: when incremented miss_cnt equals loss_count -> go HUNT, match_cnt=0, miss_cnt=0, offset unchanged; that comma is not captured.
REQ-022 SHALL form concat={word_in, prev_word} (2*word_size bits) and aligned = concat[offset+word_size-1 : offset].
REQ-023 On a valid word with pre-edge state LOCKED, aligned_out<=aligned and aligned_valid<=1 next cycle (latency 1 cycle, one word of pipeline data); includes the word causing loss of lock.
REQ-024 aligned_valid SHALL be 0 for any cycle not satisfying REQ-023; aligned_out holds last value.
REQ-025 locked and offset_out SHALL be registered copies of state==LOCKED and offset.
REQ-026 Counters SHALL be sized to hold lock_count and loss_count without wrap; saturate never needed due to REQ-018/021.

Reset
REQ-027 With reset=1 at an edge: state=HUNT, aligned_out=0, aligned_valid=0, locked=0, offset_out=0, prev_word=0, match_cnt=0, miss_cnt=0.
REQ-028 reset SHALL dominate word_valid in the same cycle; that word is discarded.

Verification
REQ-029 Reset: assert reset 1 cycle with word_valid=1 -> all outputs 0, state HUNT next cycle.
REQ-030 Lock: three valid words 0x0000000D, index_in=1 -> locked=1 and offset_out=0 after third edge, not earlier.
REQ-031 Align: locked at offset 4, prev_word=0x87654321, word_in=0x0000000F valid -> aligned_out=0xF8765432, aligned_valid=1 next cycle.
REQ-032 Loss: locked offset 0, four valid words with index_in=9 -> locked stays 1 after 3, drops after 4th, state HUNT, aligned_valid=1 for all four.
REQ-033 Re-verify: index_in 1,1,5,5,5 on valid words -> locked=1 only after fifth, offset_out=4.
REQ-034 Mid-operation reset and invalid gaps: locked, word_valid=0 for 5 cycles -> no output change; then reset -> locked=0, aligned_valid=0; index_in=31 in HUNT -> stays HUNT.
